systolic_seq_ctrl: RTL and testbench

//  Sequencer for the NxN PE systolic MAC array. Fetches one A column / B row per cycle from the operand

---
 rtl/systolic_seq_ctrl_if.sv | 36 +++
 rtl/systolic_seq_ctrl.sv | 108 ++++++++++
 tb/tb_systolic_seq_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/systolic_seq_ctrl_if.sv
// Host, operand-buffer, PE-array and result-buffer signals of the systolic sequencer.
// The controller takes the master modport; the surrounding datapath takes the slave modport.
interface systolic_seq_ctrl_if #(
    parameter int N  = 4,
    parameter int KW = 8,
    parameter int AW = 8
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic          start;
    logic          abort;
    logic [KW-1:0] k_len;
    logic          busy;
    logic          done;
    logic          op_rd_en;
    logic [AW-1:0] op_rd_addr;
    logic          arr_en;
    logic          arr_clr;
    logic          zero_pad;
    logic [N-1:0]  row_vld;
    logic          res_wr_en;
    logic [RW-1:0] res_row;
    logic [31:0]   perf_cyc;

    modport master (
        input  start, abort, k_len,
        output busy, done, op_rd_en, op_rd_addr, arr_en, arr_clr, zero_pad,
               row_vld, res_wr_en, res_row, perf_cyc
    );

    modport slave (
        output start, abort, k_len,
        input  busy, done, op_rd_en, op_rd_addr, arr_en, arr_clr, zero_pad,
               row_vld, res_wr_en, res_row, perf_cyc
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Systolic MAC sequencer: clear, feed K operands, drain, read out N rows, pulse done; start-to-done 3+K+DRAIN+N cycles (K>0).
// No backpressure, abort returns to IDLE at once; SYSTOLIC_PERF_CNT_EN adds the per-job cycle counter on perf_cyc.
module systolic_seq_ctrl #(
    parameter int N     = 4,
    parameter int KW    = 8,
    parameter int AW    = 8,
    parameter int DRAIN = 6
) (
    input  logic                clk,
    input  logic                rst_b,
    systolic_seq_ctrl_if.master bus
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_READOUT, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [KW-1:0] k_lat;
    logic [KW-1:0] kcnt;
    logic [RW-1:0] rcnt;
    logic          arr_en_q;
    logic          zero_pad_q;
    logic [N-2:0]  vld_sr;
    logic          abort_act;
    logic          vld_term;

    assign abort_act = bus.abort && (state != S_IDLE);
    assign vld_term  = arr_en_q && !zero_pad_q;

    always_ff @(posedge clk) begin
        if (!rst_b) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort_act) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (bus.start && !bus.abort) state_nxt = S_CLEAR;
                S_CLEAR:   state_nxt = (k_lat != '0) ? S_FEED : S_READOUT;
                S_FEED:    if (kcnt == k_lat - 1'b1) state_nxt = S_DRAIN;
                S_DRAIN:   if (kcnt == KW'(DRAIN - 1)) state_nxt = S_READOUT;
                S_READOUT: if (rcnt == RW'(N - 1)) state_nxt = S_DONE;
                S_DONE:    state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // arr_en/zero_pad follow the operand data, which lags the read strobe by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            k_lat      <= '0;
            kcnt       <= '0;
            rcnt       <= '0;
            arr_en_q   <= 1'b0;
            zero_pad_q <= 1'b0;
            vld_sr     <= '0;
        end else begin
            if (state == S_IDLE && bus.start) k_lat <= bus.k_len;
            kcnt       <= (state_nxt == state && (state == S_FEED || state == S_DRAIN))
                          ? kcnt + 1'b1 : '0;
            rcnt       <= (state == S_READOUT && state_nxt == S_READOUT) ? rcnt + 1'b1 : '0;
            arr_en_q   <= (state == S_FEED || state == S_DRAIN) && !abort_act;
            zero_pad_q <= (state == S_DRAIN) && !abort_act;
            vld_sr     <= abort_act ? '0 : bus.row_vld[N-2:0];
        end
    end

    always_comb begin
        bus.busy       = (state != S_IDLE);
        bus.done       = (state == S_DONE);
        bus.op_rd_en   = (state == S_FEED);
        bus.op_rd_addr = (state == S_FEED) ? AW'(kcnt) : '0;
        bus.arr_clr    = (state == S_CLEAR);
        bus.res_wr_en  = (state == S_READOUT);
        bus.res_row    = rcnt;
        bus.arr_en     = arr_en_q;
        bus.zero_pad   = zero_pad_q;
        bus.row_vld    = {vld_sr, vld_term};
    end

`ifdef SYSTOLIC_PERF_CNT_EN
    logic [31:0] job_cyc;
    logic [31:0] perf_q;

    // job_cyc starts at 1 for the accepting cycle, so perf_cyc is the inclusive start-to-done count.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            job_cyc <= '0;
            perf_q  <= '0;
        end else begin
            if (state == S_IDLE && bus.start && !bus.abort) job_cyc <= 32'd1;
            else if (state != S_IDLE && job_cyc != '1)      job_cyc <= job_cyc + 32'd1;
            if (state == S_DONE && !abort_act)
                perf_q <= (job_cyc == '1) ? job_cyc : job_cyc + 32'd1;
        end
    end

    assign bus.perf_cyc = perf_q;
`else
    assign bus.perf_cyc = 32'd0;
`endif
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: directed jobs plus random start/abort/reset traffic,
// compared each cycle against a job-timeline reference model.
module tb_systolic_seq_ctrl;
    localparam int N     = 4;
    localparam int KW    = 8;
    localparam int AW    = 8;
    localparam int DRAIN = 6;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    systolic_seq_ctrl_if #(.N(N), .KW(KW), .AW(AW)) bus ();

    systolic_seq_ctrl #(.N(N), .KW(KW), .AW(AW), .DRAIN(DRAIN)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: d = cycle offset inside the current job (1 = CLEAR cycle), 0 = idle.
    int d        = 0;
    int mk       = 0;
    int perf_exp = 0;
    int done_cnt = 0;
    int arr_cnt  = 0;
    int wr_cnt   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int done_off(input int k);
        return 2 + ((k > 0) ? k + DRAIN : 0) + N;
    endfunction

    task automatic compare();
        int p;
        bit act, rd, arr, zp, wr, dn, clr;
        logic [N-1:0] rv;
        p   = (mk > 0) ? mk + DRAIN : 0;
        act = (d > 0);
        rd  = act && mk > 0 && d >= 2 && d <= mk + 1;
        arr = act && mk > 0 && d >= 3 && d <= mk + DRAIN + 2;
        zp  = act && mk > 0 && d >= mk + 3 && d <= mk + DRAIN + 2;
        wr  = act && d >= 2 + p && d <= 1 + p + N;
        dn  = act && d == 2 + p + N;
        clr = act && d == 1;
        for (int i = 0; i < N; i++) rv[i] = act && mk > 0 && d >= 3 + i && d <= mk + 2 + i;
        chk("ctrl", {bus.busy, bus.done, bus.op_rd_en, bus.arr_en, bus.arr_clr, bus.zero_pad, bus.res_wr_en},
            {act, dn, rd, arr, clr, zp, wr});
        chk("addr", bus.op_rd_addr, rd ? d - 2 : 0);
        chk("rowv", bus.row_vld, rv);
        chk("rrow", bus.res_row, wr ? d - 2 - p : 0);
        chk("perf", bus.perf_cyc, perf_exp);
        done_cnt += int'(bus.done);
        arr_cnt  += int'(bus.arr_en);
        wr_cnt   += int'(bus.res_wr_en);
    endtask

    task automatic step(input logic s, input logic a, input logic r, input int k);
        bus.start = s;
        bus.abort = a;
        rst_b     = r;
        bus.k_len = KW'(k);
        @(posedge clk);
        if (!r) begin
            d        = 0;
            perf_exp = 0;
        end else if (d > 0) begin
            if (a) begin
                d = 0;
            end else if (d == done_off(mk)) begin
`ifdef SYSTOLIC_PERF_CNT_EN
                perf_exp = done_off(mk) + 1;
`endif
                d = 0;
            end else begin
                d++;
            end
        end else if (s && !a) begin
            d  = 1;
            mk = k;
        end
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 0);
    endtask

    task automatic run_job(input int k, input string tag);
        int j;
        done_cnt = 0;
        arr_cnt  = 0;
        wr_cnt   = 0;
        step(1'b1, 1'b0, 1'b1, k);
        j = 1;
        while (done_cnt == 0 && j < 400) begin
            step(1'b0, 1'b0, 1'b1, 0);
            j++;
        end
        chk({tag, "_lat"}, j + 1, 3 + N + k + ((k > 0) ? DRAIN : 0));
        chk({tag, "_arr"}, arr_cnt, (k > 0) ? k + DRAIN : 0);
        chk({tag, "_wr"}, wr_cnt, N);
        idle(2);
    endtask

    initial begin
        int r_i, s_i, a_i, k_i;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.k_len = '0;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0);
        idle(2);

        run_job(4, "t1");
        run_job(0, "t2");
        run_job(1, "k1");

        // start held through a whole job: only one job may run
        done_cnt = 0;
        for (int i = 0; i < 3 + N + 2 + DRAIN; i++) step(1'b1, 1'b0, 1'b1, 2);
        idle(20);
        chk("t3_dones", done_cnt, 1);
        run_job(2, "t3b");

        // abort in the third FEED cycle
        done_cnt = 0;
        step(1'b1, 1'b0, 1'b1, 5);
        idle(3);
        step(1'b0, 1'b1, 1'b1, 0);
        chk("t4_busy", bus.busy, 1'b0);
        idle(20);
        chk("t4_dones", done_cnt, 0);
        run_job(3, "t4b");

        // abort and start together in IDLE: nothing starts
        step(1'b1, 1'b1, 1'b1, 4);
        chk("t4_sa", bus.busy, 1'b0);

        // reset during READOUT, then a clean K=4 job
        step(1'b1, 1'b0, 1'b1, 4);
        idle(12);
        step(1'b0, 1'b0, 1'b0, 0);
        chk("t5_rst", {bus.busy, bus.res_wr_en, bus.perf_cyc}, 0);
        run_job(4, "t5");
`ifdef SYSTOLIC_PERF_CNT_EN
        chk("t5_perf", bus.perf_cyc, 17);
`else
        chk("t5_perf", bus.perf_cyc, 0);
`endif

        run_job(255, "kmax");

        for (int i = 0; i < 1500; i++) begin
            r_i = ($urandom_range(0, 299) != 0) ? 1 : 0;
            s_i = ($urandom_range(0, 3) == 0) ? 1 : 0;
            a_i = ($urandom_range(0, 39) == 0) ? 1 : 0;
            k_i = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
            step(r_i[0] ? s_i[0] : 1'b0, a_i[0], r_i[0], k_i);
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
